axi4_lite_csr_initiator: RTL
============================

Name: axi4_lite_csr_initiator

Overview:
- AXI4-Lite master that turns a simple command/response stream into single AXI4-Lite register transactions.
- Used by on-chip sequencers and debug/bring-up logic to program CSR slaves (white-balance, other img_proc blocks) without a CPU.
- One transaction outstanding at a time; write and read responses are returned on one response port, with error and timeout flags.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles an active transaction may wait before it is aborted; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted
- cmd_we_i  input  1  1 = write, 0 = read
- cmd_addr_i  input  32  byte address
- cmd_wdata_i  input  32  write data
- cmd_wstrb_i  input  4  write byte strobes
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_rdata_o  output  32  read data; 0 for writes and timeouts
- rsp_err_o  output  1  resp != 2'b00, or timeout
- rsp_timeout_o  output  1  transaction aborted by timeout
- csr_o  axi4_lite_if.master  -  AXI4-Lite master port (aw/w/b/ar/r channels)

Behaviour:
- FSM states: IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RSP.
- cmd_ready_o = (state == IDLE).
- Command handshake (cmd_valid_i && cmd_ready_o) registers addr, wdata, wstrb and we.
- After a write command the FSM goes to WR_ADDR_DATA; after a read command it goes to RD_ADDR.
- Write path:
  - awvalid and wvalid assert one cycle after the command handshake.
  - Each channel is tracked separately (aw_done, w_done) and deasserts its valid the cycle after its own handshake. Either order is legal, including both in the same cycle.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - When both are done, go to WAIT_B with bready = 1.
  - On bvalid && bready: capture bresp, drop bready, go to RSP. rsp_rdata_o = 0.
- Read path:
  - arvalid asserts one cycle after the command handshake and is held until arready.
  - Then go to WAIT_R with rready = 1.
  - On rvalid && rready: capture rdata and rresp, drop rready, go to RSP.
- RSP state:
  - rsp_valid_o = 1 from the cycle after the B/R handshake.
  - rsp_rdata_o, rsp_err_o and rsp_timeout_o are stable while rsp_valid_o is high.
  - On rsp_valid_o && rsp_ready_i, go to IDLE; the next command can be accepted in that same next cycle.
- Minimum write latency with a zero-wait slave: command handshake at N, aw/w handshake at N+1, B handshake at N+2 or later, rsp_valid_o at N+3.
- Timeout:
  - 32-bit counter clears in IDLE and RSP and increments every cycle in any other state.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), all of awvalid, wvalid, arvalid, bready and rready deassert that same cycle.
  - Response for an aborted transaction: rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0; FSM goes to RSP.
  - This abort is a deliberate AXI rule violation, accepted for hung slaves during bring-up.
- A B/R handshake in the same cycle as timeout expiry counts as a normal completion; the timeout is ignored.
- Reset, asynchronous and effective mid-transaction:
  - state = IDLE.
  - awvalid, wvalid, arvalid, bready, rready = 0.
  - rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_rdata_o = 0.
  - awaddr, araddr, wdata = 0; wstrb = 0.
  - cmd_ready_o = 1 once reset is released.
- No pending-command queue: cmd_valid_i held while cmd_ready_o = 0 is simply stalled.

Test Plan:
- Write 0x0000_0004 / data 0x1 / wstrb 0x1, slave with zero wait states -> awvalid and wvalid high on cycle N+1; one rsp with err = 0, timeout = 0, rdata = 0x0.
- Write 0x0000_000C / data 0x1234_5678 / wstrb 0xF, slave holds awready low 3 cycles but takes W immediately -> wvalid low after 1 cycle, awvalid held stable 4 cycles; exactly one rsp, err = 0.
- Read 0x0000_000C, slave returns rvalid 2 cycles after AR with 0xDEAD_BEEF and rresp 00 -> rsp_rdata_o = 0xDEAD_BEEF, err = 0.
- Write where the slave returns bresp 2'b10 -> rsp_err_o = 1, rsp_timeout_o = 0.
- TIMEOUT_CYCLES = 16, slave never asserts arready -> rsp_valid_o 17 cycles after the command handshake with err = 1, timeout = 1, rdata = 0; arvalid low from the expiry cycle.
- rsp_ready_i held low 5 cycles -> rsp outputs stable and cmd_ready_o = 0 throughout. Then assert rst_i during WAIT_B of the next write -> all AXI valid/ready signals and rsp_valid_o are 0 immediately, and cmd_ready_o = 1 after release.

Source files
------------

// File: rtl/axi4_lite_csr_initiator_if.sv
// AXI4-Lite bus bundle shared by the CSR initiator and its register slaves.
interface axi4_lite_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_csr_initiator.sv
// Single-outstanding AXI4-Lite master: command stream in, one response per command out,
// with an optional abort of transactions stuck on a hung slave.
module axi4_lite_csr_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    axi4_lite_if.master csr_o
);

    // state        | meaning
    // IDLE         | waiting for a command
    // WR_ADDR_DATA | driving AW and W until each has handshaken
    // WAIT_B       | bready high, waiting for write response
    // RD_ADDR      | driving AR until arready
    // WAIT_R       | rready high, waiting for read data
    // RSP          | response held on the rsp port until consumed
    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RSP
    } state_e;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        to_q, to_d;
    logic [31:0] cnt_q, cnt_d;

    logic timeout_hit;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

    // Valids drop combinationally on expiry; readies stay up if the handshake lands
    // on the expiry cycle so that completion wins over the abort.
    assign awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q && !timeout_hit;
    assign wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q && !timeout_hit;
    assign bready  = (state_q == WAIT_B) && (!timeout_hit || csr_o.bvalid);
    assign arvalid = (state_q == RD_ADDR) && !timeout_hit;
    assign rready  = (state_q == WAIT_R) && (!timeout_hit || csr_o.rvalid);

    assign aw_hs = awvalid && csr_o.awready;
    assign w_hs  = wvalid && csr_o.wready;
    assign b_hs  = bready && csr_o.bvalid;
    assign ar_hs = arvalid && csr_o.arready;
    assign r_hs  = rready && csr_o.rvalid;

    assign csr_o.awvalid = awvalid;
    assign csr_o.awaddr  = addr_q;
    assign csr_o.wvalid  = wvalid;
    assign csr_o.wdata   = wdata_q;
    assign csr_o.wstrb   = wstrb_q;
    assign csr_o.bready  = bready;
    assign csr_o.arvalid = arvalid;
    assign csr_o.araddr  = addr_q;
    assign csr_o.rready  = rready;

    assign cmd_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RSP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = to_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        to_d      = to_q;
        cnt_d     = cnt_q + 32'd1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid_i) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we_i ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RSP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_hs) begin
                    rdata_d = '0;
                    err_d   = (csr_o.bresp != 2'b00);
                    to_d    = 1'b0;
                    state_d = RSP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RSP;
                end else if (ar_hs) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (r_hs) begin
                    rdata_d = csr_o.rdata;
                    err_d   = (csr_o.rresp != 2'b00);
                    to_d    = 1'b0;
                    state_d = RSP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                cnt_d = '0;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
